// File: rtl/clusterv_main_sram_arbiter.sv
// Two-requester arbiter in front of a single-port byte-enable SRAM.
// Grants at most one access per cycle (round-robin or fixed priority) and
// routes the one-cycle-latency read data back to the requester that issued it.
module clusterv_main_sram_arbiter #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned FIXED_PRIO = 0
) (
   input  logic                      clock,
   input  logic                      reset,

   input  logic                      r0_req,
   input  logic                      r0_we,
   input  logic [ADDR_WIDTH-1:0]     r0_addr,
   input  logic [DATA_WIDTH-1:0]     r0_wdata,
   input  logic [DATA_WIDTH/8-1:0]   r0_byte_en,
   output logic                      r0_gnt,
   output logic                      r0_rvalid,
   output logic [DATA_WIDTH-1:0]     r0_rdata,

   input  logic                      r1_req,
   input  logic                      r1_we,
   input  logic [ADDR_WIDTH-1:0]     r1_addr,
   input  logic [DATA_WIDTH-1:0]     r1_wdata,
   input  logic [DATA_WIDTH/8-1:0]   r1_byte_en,
   output logic                      r1_gnt,
   output logic                      r1_rvalid,
   output logic [DATA_WIDTH-1:0]     r1_rdata,

   output logic [ADDR_WIDTH-1:0]     t_addr,
   output logic                      t_read_en,
   output logic                      t_write_en,
   output logic [DATA_WIDTH/8-1:0]   t_byte_en,
   output logic [DATA_WIDTH-1:0]     t_write_data,
   input  logic [DATA_WIDTH-1:0]     t_read_data
);

   localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
   localparam bit          USE_FIXED = (FIXED_PRIO != 0);

   // Arbiter and read-return state
   logic last_gnt, last_gnt_d;
   logic rd_pend,  rd_pend_d;
   logic rd_owner, rd_owner_d;

   // Per-cycle decision
   logic gnt0, gnt1, any_gnt, win_we;

   // Pick the winner; last_gnt names the requester served most recently.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (reset) begin
         if (r0_req && r1_req) begin
            if (USE_FIXED || last_gnt) begin
               gnt0 = 1'b1;
            end else begin
               gnt1 = 1'b1;
            end
         end else begin
            gnt0 = r0_req;
            gnt1 = r1_req;
         end
      end
   end

   assign any_gnt = gnt0 | gnt1;
   assign r0_gnt  = gnt0;
   assign r1_gnt  = gnt1;

   // Steer the winner's command onto the SRAM port; park at zero when idle.
   always_comb begin
      win_we       = 1'b0;
      t_addr       = '0;
      t_byte_en    = '0;
      t_write_data = '0;
      if (gnt0) begin
         win_we       = r0_we;
         t_addr       = r0_addr;
         t_byte_en    = r0_byte_en;
         t_write_data = r0_wdata;
      end else if (gnt1) begin
         win_we       = r1_we;
         t_addr       = r1_addr;
         t_byte_en    = r1_byte_en;
         t_write_data = r1_wdata;
      end
   end

   assign t_read_en  = any_gnt & ~win_we;
   assign t_write_en = any_gnt &  win_we;

   // Next-state: priority moves only on a grant; a read grant books the return slot.
   always_comb begin
      last_gnt_d = last_gnt;
      rd_pend_d  = 1'b0;
      rd_owner_d = rd_owner;
      if (any_gnt) begin
         last_gnt_d = gnt1;
      end
      if (t_read_en) begin
         rd_pend_d  = 1'b1;
         rd_owner_d = gnt1;
      end
   end

   // State registers; reset hands the first conflict to requester 0.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         last_gnt <= 1'b1;
         rd_pend  <= 1'b0;
         rd_owner <= 1'b0;
      end else begin
         last_gnt <= last_gnt_d;
         rd_pend  <= rd_pend_d;
         rd_owner <= rd_owner_d;
      end
   end

   // Return path: SRAM data goes only to the owner of the pending read.
   assign r0_rvalid = rd_pend & ~rd_owner;
   assign r1_rvalid = rd_pend &  rd_owner;
   assign r0_rdata  = r0_rvalid ? t_read_data : {DATA_WIDTH{1'b0}};
   assign r1_rdata  = r1_rvalid ? t_read_data : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_clusterv_main_sram_arbiter.sv
// Bench for clusterv_main_sram_arbiter: directed table, hand-written reset and
// contention sequences, then random traffic against a transaction-level model.
module tb_clusterv_main_sram_arbiter;

   localparam int unsigned AW = 10;
   localparam int unsigned DW = 32;
   localparam int unsigned BW = DW / 8;

   logic clock = 1'b0;
   logic reset = 1'b0;

   logic          r0_req, r0_we, r1_req, r1_we;
   logic [AW-1:0] r0_addr, r1_addr;
   logic [DW-1:0] r0_wdata, r1_wdata;
   logic [BW-1:0] r0_byte_en, r1_byte_en;

   // Round-robin instance outputs
   logic          a_r0_gnt, a_r0_rvalid, a_r1_gnt, a_r1_rvalid;
   logic [DW-1:0] a_r0_rdata, a_r1_rdata;
   logic [AW-1:0] a_t_addr;
   logic          a_t_read_en, a_t_write_en;
   logic [BW-1:0] a_t_byte_en;
   logic [DW-1:0] a_t_write_data;

   // Fixed-priority instance outputs
   logic          f_r0_gnt, f_r0_rvalid, f_r1_gnt, f_r1_rvalid;
   logic [DW-1:0] f_r0_rdata, f_r1_rdata;
   logic [AW-1:0] f_t_addr;
   logic          f_t_read_en, f_t_write_en;
   logic [BW-1:0] f_t_byte_en;
   logic [DW-1:0] f_t_write_data;

   // SRAM model behind the round-robin instance
   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [DW-1:0] sram_q = '0;

   int n_cmp = 0;
   int n_bad = 0;

   clusterv_main_sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(0)) u_dut (
      .clock(clock), .reset(reset),
      .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_byte_en(r0_byte_en),
      .r0_gnt(a_r0_gnt), .r0_rvalid(a_r0_rvalid), .r0_rdata(a_r0_rdata),
      .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_byte_en(r1_byte_en),
      .r1_gnt(a_r1_gnt), .r1_rvalid(a_r1_rvalid), .r1_rdata(a_r1_rdata),
      .t_addr(a_t_addr), .t_read_en(a_t_read_en), .t_write_en(a_t_write_en),
      .t_byte_en(a_t_byte_en), .t_write_data(a_t_write_data), .t_read_data(sram_q)
   );

   clusterv_main_sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(1)) u_dut_fixed (
      .clock(clock), .reset(reset),
      .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_byte_en(r0_byte_en),
      .r0_gnt(f_r0_gnt), .r0_rvalid(f_r0_rvalid), .r0_rdata(f_r0_rdata),
      .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_byte_en(r1_byte_en),
      .r1_gnt(f_r1_gnt), .r1_rvalid(f_r1_rvalid), .r1_rdata(f_r1_rdata),
      .t_addr(f_t_addr), .t_read_en(f_t_read_en), .t_write_en(f_t_write_en),
      .t_byte_en(f_t_byte_en), .t_write_data(f_t_write_data), .t_read_data(sram_q)
   );

   always #5 clock = ~clock;

   // Synchronous SRAM with byte lanes and one-cycle read latency
   always @(posedge clock) begin
      if (a_t_write_en) begin
         for (int b = 0; b < int'(BW); b++) begin
            if (a_t_byte_en[b]) mem[a_t_addr][8*b +: 8] <= a_t_write_data[8*b +: 8];
         end
      end
      if (a_t_read_en) sram_q <= mem[a_t_addr];
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic q0, input logic w0, input logic [AW-1:0] a0,
                        input logic [DW-1:0] d0, input logic [BW-1:0] b0,
                        input logic q1, input logic w1, input logic [AW-1:0] a1,
                        input logic [DW-1:0] d1, input logic [BW-1:0] b1);
      r0_req = q0; r0_we = w0; r0_addr = a0; r0_wdata = d0; r0_byte_en = b0;
      r1_req = q1; r1_we = w1; r1_addr = a1; r1_wdata = d1; r1_byte_en = b1;
   endtask

   task automatic drive_idle();
      drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
   endtask

   // Hold reset two cycles with both requesting; nothing may be granted or returned.
   task automatic do_reset();
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b0, 10'h005, '0, '0, 1'b1, 1'b1, 10'h009, 32'h1, 4'hF);
         #2;
         check("rst_gnt0",   64'(a_r0_gnt), 64'(0));
         check("rst_gnt1",   64'(a_r1_gnt), 64'(0));
         check("rst_ten",    64'({a_t_write_en, a_t_read_en}), 64'(0));
         check("rst_rvalid", 64'({a_r1_rvalid, a_r0_rvalid}), 64'(0));
         check("rst_fgnt",   64'({f_r1_gnt, f_r0_gnt}), 64'(0));
         next_cycle();
      end
      reset = 1'b1;
   endtask

   typedef struct packed {
      logic          q0; logic w0; logic [AW-1:0] a0; logic [DW-1:0] d0; logic [BW-1:0] b0;
      logic          q1; logic w1; logic [AW-1:0] a1; logic [DW-1:0] d1; logic [BW-1:0] b1;
      logic [1:0]    gnt;  // {r1,r0}
      logic [1:0]    ten;  // {write_en,read_en}
      logic [1:0]    rv;   // {r1,r0}
      logic [DW-1:0] rd;
   } vec_t;

   localparam int NVEC = 13;
   vec_t tbl [NVEC];

   // Random-phase model state
   int            prio;
   bit            exp_pv;
   int            exp_po;
   logic [DW-1:0] exp_pd;
   logic [DW-1:0] shadow [0:15];
   bit            act [2];
   logic          rwe  [2];
   logic [AW-1:0] rad  [2];
   logic [DW-1:0] rwd  [2];
   logic [BW-1:0] rbe  [2];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
      $fatal(1);
   end

   initial begin
      vec_t v;
      logic [AW-1:0] exp_addr;
      int win;

      //              q0   w0   a0       d0            b0    q1   w1   a1       d1            b1    gnt    ten    rv     rd
      tbl[0]  = '{1'b1,1'b1,10'h005,32'hDEADBEEF,4'hF, 1'b1,1'b0,10'h005,32'h0,       4'h0, 2'b01, 2'b10, 2'b00, 32'h0};
      tbl[1]  = '{1'b0,1'b0,10'h000,32'h0,       4'h0, 1'b1,1'b0,10'h005,32'h0,       4'h0, 2'b10, 2'b01, 2'b00, 32'h0};
      tbl[2]  = '{1'b0,1'b0,10'h000,32'h0,       4'h0, 1'b0,1'b0,10'h000,32'h0,       4'h0, 2'b00, 2'b00, 2'b10, 32'hDEADBEEF};
      tbl[3]  = '{1'b1,1'b0,10'h005,32'h0,       4'h0, 1'b0,1'b0,10'h000,32'h0,       4'h0, 2'b01, 2'b01, 2'b00, 32'h0};
      tbl[4]  = '{1'b0,1'b0,10'h000,32'h0,       4'h0, 1'b0,1'b0,10'h000,32'h0,       4'h0, 2'b00, 2'b00, 2'b01, 32'hDEADBEEF};
      tbl[5]  = '{1'b0,1'b0,10'h000,32'h0,       4'h0, 1'b1,1'b1,10'h009,32'hAAAAAAAA,4'hF, 2'b10, 2'b10, 2'b00, 32'h0};
      tbl[6]  = '{1'b0,1'b0,10'h000,32'h0,       4'h0, 1'b1,1'b1,10'h009,32'h11223344,4'h5, 2'b10, 2'b10, 2'b00, 32'h0};
      tbl[7]  = '{1'b0,1'b0,10'h000,32'h0,       4'h0, 1'b1,1'b0,10'h009,32'h0,       4'h0, 2'b10, 2'b01, 2'b00, 32'h0};
      tbl[8]  = '{1'b0,1'b0,10'h000,32'h0,       4'h0, 1'b0,1'b0,10'h000,32'h0,       4'h0, 2'b00, 2'b00, 2'b10, 32'hAA22AA44};
      tbl[9]  = '{1'b1,1'b0,10'h005,32'h0,       4'h0, 1'b1,1'b0,10'h005,32'h0,       4'h0, 2'b01, 2'b01, 2'b00, 32'h0};
      tbl[10] = '{1'b1,1'b0,10'h009,32'h0,       4'h0, 1'b1,1'b0,10'h005,32'h0,       4'h0, 2'b10, 2'b01, 2'b01, 32'hDEADBEEF};
      tbl[11] = '{1'b1,1'b0,10'h009,32'h0,       4'h0, 1'b0,1'b0,10'h000,32'h0,       4'h0, 2'b01, 2'b01, 2'b10, 32'hDEADBEEF};
      tbl[12] = '{1'b0,1'b0,10'h000,32'h0,       4'h0, 1'b0,1'b0,10'h000,32'h0,       4'h0, 2'b00, 2'b00, 2'b01, 32'hAA22AA44};

      for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
      drive_idle();
      do_reset();

      // Directed table, starting in the very first cycle after release
      for (int i = 0; i < NVEC; i++) begin
         v = tbl[i];
         drive(v.q0, v.w0, v.a0, v.d0, v.b0, v.q1, v.w1, v.a1, v.d1, v.b1);
         #2;
         exp_addr = v.gnt[0] ? v.a0 : (v.gnt[1] ? v.a1 : '0);
         check($sformatf("vec%0d_gnt", i),    64'({a_r1_gnt, a_r0_gnt}), 64'(v.gnt));
         check($sformatf("vec%0d_ten", i),    64'({a_t_write_en, a_t_read_en}), 64'(v.ten));
         check($sformatf("vec%0d_taddr", i),  64'(a_t_addr), 64'(exp_addr));
         check($sformatf("vec%0d_rvalid", i), 64'({a_r1_rvalid, a_r0_rvalid}), 64'(v.rv));
         check($sformatf("vec%0d_rdata0", i), 64'(a_r0_rdata), 64'(v.rv[0] ? v.rd : 32'h0));
         check($sformatf("vec%0d_rdata1", i), 64'(a_r1_rdata), 64'(v.rv[1] ? v.rd : 32'h0));
         next_cycle();
      end

      // Sustained contention from reset: round-robin alternates, fixed priority starves r1
      do_reset();
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 1'b0, 10'h005, '0, '0, 1'b1, 1'b0, 10'h009, '0, '0);
         #2;
         check($sformatf("cont%0d_gnt0", i),  64'(a_r0_gnt), 64'(i % 2 == 0));
         check($sformatf("cont%0d_gnt1", i),  64'(a_r1_gnt), 64'(i % 2 == 1));
         check($sformatf("cont%0d_fgnt", i),  64'({f_r1_gnt, f_r0_gnt}), 64'(2'b01));
         check($sformatf("cont%0d_rv0", i),   64'(a_r0_rvalid), 64'(i % 2 == 1));
         check($sformatf("cont%0d_rv1", i),   64'(a_r1_rvalid), 64'(i > 0 && i % 2 == 0));
         check($sformatf("cont%0d_rd0", i),   64'(a_r0_rdata), 64'((i % 2 == 1) ? 32'hDEADBEEF : 32'h0));
         check($sformatf("cont%0d_rd1", i),   64'(a_r1_rdata), 64'((i > 0 && i % 2 == 0) ? 32'hAA22AA44 : 32'h0));
         next_cycle();
      end

      // Reset mid-read: r0 served last, then r1 read granted and reset hits before its edge
      drive(1'b1, 1'b0, 10'h005, '0, '0, 1'b0, 1'b0, '0, '0, '0);
      #2;
      check("mr_gnt0", 64'(a_r0_gnt), 64'(1));
      check("mr_rv1",  64'({a_r1_rvalid, a_r1_rdata}), 64'({1'b1, 32'hAA22AA44}));
      next_cycle();
      drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 10'h009, '0, '0);
      #2;
      check("mr_gnt1",     64'(a_r1_gnt), 64'(1));
      check("mr_overlap0", 64'({a_r0_rvalid, a_r0_rdata}), 64'({1'b1, 32'hDEADBEEF}));
      #1;
      reset = 1'b0;
      #1;
      check("mr_rst_gnt1", 64'(a_r1_gnt), 64'(0));
      check("mr_rst_rv",   64'({a_r1_rvalid, a_r0_rvalid}), 64'(0));
      drive_idle();
      next_cycle();
      check("mr_hold_rv",  64'({a_r1_rvalid, a_r0_rvalid}), 64'(0));
      next_cycle();
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #2;
         check($sformatf("mr_post%0d_rv", i), 64'({a_r1_rvalid, a_r0_rvalid}), 64'(0));
         next_cycle();
      end
      drive(1'b1, 1'b0, 10'h005, '0, '0, 1'b1, 1'b0, 10'h009, '0, '0);
      #2;
      check("mr_conf_gnt", 64'({a_r1_gnt, a_r0_gnt}), 64'(2'b01));
      next_cycle();
      drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 10'h009, '0, '0);
      #2;
      check("mr_conf_gnt1", 64'({a_r1_gnt, a_r0_gnt}), 64'(2'b10));
      check("mr_conf_rd0",  64'({a_r0_rvalid, a_r0_rdata}), 64'({1'b1, 32'hDEADBEEF}));
      next_cycle();
      drive_idle();
      #2;
      check("mr_conf_rd1",  64'({a_r1_rvalid, a_r1_rdata}), 64'({1'b1, 32'hAA22AA44}));
      next_cycle();

      // Random traffic against a transaction-level model
      do_reset();
      for (int i = 0; i < 16; i++) shadow[i] = mem[i];
      prio   = 0;
      exp_pv = 1'b0;
      exp_po = 0;
      exp_pd = '0;
      act[0] = 1'b0;
      act[1] = 1'b0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         for (int k = 0; k < 2; k++) begin
            if (!act[k] && $urandom_range(0, 99) < 60) begin
               act[k] = 1'b1;
               rwe[k] = 1'($urandom_range(0, 1));
               rad[k] = AW'($urandom_range(0, 15));
               rwd[k] = $urandom;
               rbe[k] = BW'($urandom_range(0, 15));
            end
         end
         drive(act[0], rwe[0], rad[0], rwd[0], rbe[0], act[1], rwe[1], rad[1], rwd[1], rbe[1]);
         #2;
         win = -1;
         if (act[0] && act[1]) win = prio;
         else if (act[0])      win = 0;
         else if (act[1])      win = 1;

         check("rnd_gnt0",  64'(a_r0_gnt), 64'(win == 0));
         check("rnd_gnt1",  64'(a_r1_gnt), 64'(win == 1));
         check("rnd_fgnt0", 64'(f_r0_gnt), 64'(act[0]));
         check("rnd_fgnt1", 64'(f_r1_gnt), 64'(!act[0] && act[1]));
         check("rnd_rv0",   64'(a_r0_rvalid), 64'(exp_pv && exp_po == 0));
         check("rnd_rv1",   64'(a_r1_rvalid), 64'(exp_pv && exp_po == 1));
         check("rnd_rd0",   64'(a_r0_rdata), 64'((exp_pv && exp_po == 0) ? exp_pd : 32'h0));
         check("rnd_rd1",   64'(a_r1_rdata), 64'((exp_pv && exp_po == 1) ? exp_pd : 32'h0));
         if (win >= 0) begin
            check("rnd_ren",   64'(a_t_read_en),    64'(!rwe[win]));
            check("rnd_wen",   64'(a_t_write_en),   64'(rwe[win]));
            check("rnd_taddr", 64'(a_t_addr),       64'(rad[win]));
            check("rnd_twd",   64'(a_t_write_data), 64'(rwd[win]));
            check("rnd_tbe",   64'(a_t_byte_en),    64'(rbe[win]));
         end else begin
            check("rnd_idle_ten", 64'({a_t_write_en, a_t_read_en}), 64'(0));
            check("rnd_idle_pay", 64'({a_t_addr, a_t_byte_en, a_t_write_data}), 64'(0));
         end

         exp_pv = 1'b0;
         if (win >= 0) begin
            prio = 1 - win;
            if (rwe[win]) begin
               for (int b = 0; b < int'(BW); b++) begin
                  if (rbe[win][b]) shadow[rad[win][3:0]][8*b +: 8] = rwd[win][8*b +: 8];
               end
            end else begin
               exp_pv = 1'b1;
               exp_po = win;
               exp_pd = shadow[rad[win][3:0]];
            end
            act[win] = 1'b0;
         end
         next_cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/clusterv_main_sram_arbiter.md
CLUSTERV_MAIN_SRAM_ARBITER -- requirements
Module: clusterv_main_sram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10, giving the SRAM word-address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving the data width; byte-enable width is DATA_WIDTH/8.
REQ-003 The block SHALL have parameter FIXED_PRIO, default 0: 0 selects round-robin, 1 selects requester 0 always winning.
REQ-004 The block SHALL have port clock, input, 1 bit: single clock, all state on posedge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 For k in {0,1}, the block SHALL have port rK_req, input, 1 bit: requester K access request.
REQ-007 For k in {0,1}, the block SHALL have port rK_we, input, 1 bit: 1 = write, 0 = read.
REQ-008 For k in {0,1}, the block SHALL have port rK_addr, input, ADDR_WIDTH bits: word address.
REQ-009 For k in {0,1}, the block SHALL have port rK_wdata, input, DATA_WIDTH bits: write data.
REQ-010 For k in {0,1}, the block SHALL have port rK_byte_en, input, DATA_WIDTH/8 bits: write byte lanes.
REQ-011 For k in {0,1}, the block SHALL have port rK_gnt, output, 1 bit: request accepted this cycle.
REQ-012 For k in {0,1}, the block SHALL have port rK_rvalid, output, 1 bit: read data valid for requester K.
REQ-013 For k in {0,1}, the block SHALL have port rK_rdata, output, DATA_WIDTH bits: read data.
REQ-014 The block SHALL have SRAM-side outputs t_addr (ADDR_WIDTH), t_read_en (1), t_write_en (1), t_byte_en (DATA_WIDTH/8) and t_write_data (DATA_WIDTH), plus input t_read_data (DATA_WIDTH), matching the generic byte-enable SRAM target port.

Function
REQ-015 Each cycle the block SHALL grant at most one requester, and rK_gnt SHALL be combinational from rK_req and arbiter state.
REQ-016 With a single requester active, that requester SHALL be granted in the same cycle.
REQ-017 With both requesters active and FIXED_PRIO=0, the requester not granted most recently SHALL win, tracked by the 1-bit register last_gnt.
REQ-018 The last_gnt register SHALL update only on a cycle with a grant and SHALL hold otherwise.
REQ-019 With FIXED_PRIO=1, r0 SHALL win every conflict and last_gnt SHALL be ignored.
REQ-020 In a granted cycle, t_addr, t_byte_en and t_write_data SHALL equal the winner's inputs; t_write_en SHALL equal winner we; t_read_en SHALL equal ~winner we.
REQ-021 With no grant, t_read_en and t_write_en SHALL be 0, and t_addr, t_byte_en and t_write_data SHALL be 0.
REQ-022 Read latency SHALL be 1 cycle: for a read granted in cycle N, rK_rvalid SHALL be 1 in cycle N+1 only, with rK_rdata = t_read_data.
REQ-023 The block SHALL record read ownership in registers rd_pend (1 bit) and rd_owner (1 bit), set at the grant edge.
REQ-024 rK_rdata SHALL be 0 whenever rK_rvalid is 0.
REQ-025 Writes SHALL produce no rvalid and SHALL complete at the grant edge.
REQ-026 Back-to-back grants SHALL be allowed every cycle, so throughput is one access per cycle; a response in N+1 SHALL coexist with a new grant in N+1.
REQ-027 Both requesters asserting in every cycle SHALL yield strict alternation of grants 0,1,0,1... when FIXED_PRIO=0.
REQ-028 A requester SHALL hold req and its payload stable until gnt; the block SHALL not queue requests.

Reset
REQ-029 While reset is 0, last_gnt SHALL be 1 (so r0 wins the first conflict), and rd_pend and rd_owner SHALL be 0.
REQ-030 During reset, all rK_rvalid SHALL be 0; rK_gnt and the t_* enables SHALL be 0 regardless of req.
REQ-031 A reset asserted between a read grant and its response SHALL discard the response, and no rvalid SHALL appear after release.
REQ-032 Arbitration SHALL resume in the first cycle after reset deasserts.

Verification
REQ-033 The bench SHALL cover a single read: r0 reads addr 0x005 (previously written 0xDEADBEEF) -> r0_gnt in cycle N, r0_rvalid with 0xDEADBEEF in N+1, and r1_rvalid stays 0.
REQ-034 The bench SHALL cover a conflict after reset: r0 and r1 both request in the first cycle -> r0 granted, r1 granted in the next cycle, and r1 rdata returns one cycle later.
REQ-035 The bench SHALL cover sustained contention: both requesting for 6 cycles with FIXED_PRIO=0 -> grant sequence 0,1,0,1,0,1; with FIXED_PRIO=1 -> r0 every cycle and r1 never.
REQ-036 The bench SHALL cover a byte-enable write: r1 writes 0x11223344 with byte_en=4'b0101 over 0xAAAAAAAA, then reads back -> 0xAA22AA44.
REQ-037 The bench SHALL cover reset mid-read: r1 read granted, reset asserted before the next edge -> r1_rvalid never asserts, and last_gnt is 1 after release.
REQ-038 The bench SHALL cover an idle cycle: no requests -> t_read_en=0, t_write_en=0, no gnt, and last_gnt unchanged.
